// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ     = 32'd4;
  localparam int unsigned DEF_DATA_W      = 32'd8;
  localparam int unsigned DEF_TIMEOUT_CYC = 32'd1024;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SEND = 1'b1;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping cyclically.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk the requesters starting at ptr; the first hit wins and masks later ones.
  always_comb begin
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] pos_s;
    logic             hit_s;
    onehot = {NUM_REQ{1'b0}};
    idx    = {IDX_W{1'b0}};
    any    = 1'b0;
    sum_s  = {(IDX_W+1){1'b0}};
    pos_s  = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s       = {1'b0, ptr} + (IDX_W+1)'(k);
      pos_s       = (sum_s >= NUM_REQ) ? IDX_W'(sum_s - NUM_REQ) : IDX_W'(sum_s);
      hit_s       = req[pos_s] & ~any;
      onehot[pos_s] = onehot[pos_s] | hit_s;
      idx         = hit_s ? pos_s : idx;
      any         = any | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte interface among NUM_REQ clients.
// Optional idle-stall grant release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned GRANT_W    = grant_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy,
  output logic                        timeout_evt
);

  state_t               state_r;
  logic [GRANT_W-1:0]   grant_r;
  logic [NUM_REQ-1:0]   grant_oh_r;
  logic [GRANT_W-1:0]   rr_ptr_r;
  logic                 busy_r;

  logic [NUM_REQ-1:0]   pick_oh_s;
  logic [GRANT_W-1:0]   pick_idx_s;
  logic                 pick_any_s;
  logic                 send_s;
  logic                 owner_valid_s;
  logic                 owner_last_s;
  logic                 handshake_s;
  logic                 timeout_hit_s;
  logic                 release_s;
  logic [GRANT_W-1:0]   next_ptr_s;
  logic [DATA_W-1:0]    tx_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign send_s        = (state_r == ST_SEND);
  assign owner_valid_s = |(req_valid & grant_oh_r);
  assign owner_last_s  = |(req_last & grant_oh_r);
  assign handshake_s   = tx_valid & tx_ready;
  assign release_s     = (handshake_s & owner_last_s) | timeout_hit_s;
  assign next_ptr_s    = (grant_r == GRANT_W'(NUM_REQ - 1)) ? {GRANT_W{1'b0}} : grant_r + 1'b1;

  // Owner byte mux; all zero outside SEND so nothing leaks onto tx while idle or in reset.
  always_comb begin
    tx_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_data_s = tx_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_r[i] & send_s}});
    end
  end

  assign tx_valid  = send_s & owner_valid_s;
  assign tx_data   = tx_data_s;
  assign req_ready = grant_oh_r & {NUM_REQ{send_s & tx_ready}};
  assign grant_id  = grant_r;
  assign busy      = busy_r;

  // Grant FSM: lock an owner from IDLE, hold it until its last byte (or a forced release).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= {GRANT_W{1'b0}};
      grant_oh_r <= {{(NUM_REQ-1){1'b0}}, 1'b1};
      rr_ptr_r   <= {GRANT_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_r    <= pick_idx_s;
            grant_oh_r <= pick_oh_s;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (release_s) begin
            rr_ptr_r <= next_ptr_s;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            busy_r   <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = grant_w(TIMEOUT_CYC);

  logic [STALL_W-1:0] stall_cnt_r;
  logic               timeout_evt_r;

  // Only owner silence counts as a stall; tx_ready backpressure is the UART's business.
  assign timeout_hit_s = send_s & ~owner_valid_s & (stall_cnt_r == STALL_W'(TIMEOUT_CYC - 1));

  // Stall counter and the one-cycle release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r   <= {STALL_W{1'b0}};
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= timeout_hit_s;
      if (!send_s || handshake_s || timeout_hit_s) begin
        stall_cnt_r <= {STALL_W{1'b0}};
      end else if (!owner_valid_s) begin
        stall_cnt_r <= stall_cnt_r + 1'b1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign timeout_evt = timeout_evt_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_evt   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus reset and stall-timeout sequences.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid, req_last, req_ready;
  logic [31:0]   req_data;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_data;
  logic [1:0]    grant_id;
  logic          busy, timeout_evt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        tr;
    logic [31:0] rd;
    logic        ev;
    logic [7:0]  ed;
    logic [3:0]  er;
    logic        eb;
    logic [1:0]  eg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rl, input logic tr,
                              input logic [31:0] rd, input logic ev, input logic [7:0] ed,
                              input logic [3:0] er, input logic eb, input logic [1:0] eg);
    vec_t v;
    v.rv = rv; v.rl = rl; v.tr = tr; v.rd = rd;
    v.ev = ev; v.ed = ed; v.er = er; v.eb = eb; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic tr, input logic [31:0] rd);
    req_valid = rv;
    req_last  = rl;
    tx_ready  = tr;
    req_data  = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [7:0] ed,
                            input logic [3:0] er, input logic eb, input logic [1:0] eg);
    chk({tag, ".tx_valid"}, tx_valid, ev);
    if (ev) chk({tag, ".tx_data"}, tx_data, ed);
    chk({tag, ".req_ready"}, req_ready, er);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".grant_id"}, grant_id, eg);
    chk({tag, ".timeout_evt"}, timeout_evt, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    #2;
    check_outs("reset", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // All four hold single-byte packets: owners 0,1,2,3,0 with an idle cycle between.
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b1, 8'h12, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b1, 8'h13, 4'b1000, 1'b1, 2'd3));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3));
    vt.push_back(mk(4'hF, 4'hF, 1'b1, 32'h13121110, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    // Req2 sends A1,A2,A3(last) back to back.
    vt.push_back(mk(4'h4, 4'h0, 1'b1, 32'h00A10000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    vt.push_back(mk(4'h4, 4'h0, 1'b1, 32'h00A10000, 1'b1, 8'hA1, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'h4, 4'h0, 1'b1, 32'h00A20000, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'h4, 4'h4, 1'b1, 32'h00A30000, 1'b1, 8'hA3, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
    // Req1 arrives during req0 packet 10,11,12: waits until after 12.
    vt.push_back(mk(4'h1, 4'h0, 1'b1, 32'h00000010, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
    vt.push_back(mk(4'h1, 4'h0, 1'b1, 32'h00000010, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h3, 4'h0, 1'b1, 32'h00002011, 1'b1, 8'h11, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h3, 4'h1, 1'b1, 32'h00002012, 1'b1, 8'h12, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h2, 4'h2, 1'b1, 32'h00002000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    vt.push_back(mk(4'h2, 4'h2, 1'b1, 32'h00002000, 1'b1, 8'h20, 4'b0010, 1'b1, 2'd1));
    vt.push_back(mk(4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h00, 4'b0000, 1'b0, 2'd1));
    // Req0: owner gap (grant held), then tx_ready low for 5 cycles with byte held.
    vt.push_back(mk(4'h1, 4'h0, 1'b1, 32'h00000030, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1));
    vt.push_back(mk(4'h1, 4'h0, 1'b1, 32'h00000030, 1'b1, 8'h30, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h0, 4'h0, 1'b1, 32'h00000031, 1'b0, 8'h00, 4'b0001, 1'b1, 2'd0));
    for (int k = 0; k < 5; k++)
      vt.push_back(mk(4'h1, 4'h0, 1'b0, 32'h00000031, 1'b1, 8'h31, 4'b0000, 1'b1, 2'd0));
    vt.push_back(mk(4'h1, 4'h1, 1'b1, 32'h00000031, 1'b1, 8'h31, 4'b0001, 1'b1, 2'd0));
    vt.push_back(mk(4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rv, vt[i].rl, vt[i].tr, vt[i].rd);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].er, vt[i].eb, vt[i].eg);
      next_cycle();
    end

    // Reset mid-packet of req3, then req0 and req3 pending: pointer restarts at 0.
    drive(4'b1001, 4'b0000, 1'b1, 32'h50000040);
    @(negedge clk);
    check_outs("rst.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clk);
    check_outs("rst.g3", 1'b1, 8'h50, 4'b1000, 1'b1, 2'd3);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst.async", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check_outs("rst.g0", 1'b1, 8'h40, 4'b0001, 1'b1, 2'd0);
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1, 32'h00000041);
    @(negedge clk);
    check_outs("rst.last", 1'b1, 8'h41, 4'b0001, 1'b1, 2'd0);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1, 32'h0);
    @(negedge clk);
    check_outs("rst.done", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    next_cycle();

    // Req1 owns, sends one byte, then goes silent while req2 waits.
    drive(4'b0110, 4'b0000, 1'b1, 32'h00607000);
    @(negedge clk);
    chk("tmo.idle.busy", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("tmo.g1", 1'b1, 8'h70, 4'b0010, 1'b1, 2'd1);
    next_cycle();
    drive(4'b0100, 4'b0000, 1'b1, 32'h00607000);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk($sformatf("tmo.stall%0d.tx_valid", k), tx_valid, 1'b0);
      chk($sformatf("tmo.stall%0d.evt", k), timeout_evt, 1'b0);
      chk($sformatf("tmo.stall%0d.grant", k), grant_id, 2'd1);
      next_cycle();
    end
    @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
    chk("tmo.evt", timeout_evt, 1'b1);
    chk("tmo.busy_drop", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("tmo.evt_pulse", timeout_evt, 1'b0);
    chk("tmo.grant2", grant_id, 2'd2);
    chk("tmo.busy2", busy, 1'b1);
    chk("tmo.tx_valid2", tx_valid, 1'b1);
    chk("tmo.tx_data2", tx_data, 8'h60);
`else
    chk("hold.evt", timeout_evt, 1'b0);
    chk("hold.busy", busy, 1'b1);
    chk("hold.grant", grant_id, 2'd1);
    repeat (30) next_cycle();
    @(negedge clk);
    chk("hold.late.grant", grant_id, 2'd1);
    chk("hold.late.busy", busy, 1'b1);
    chk("hold.late.tx_valid", tx_valid, 1'b0);
    chk("hold.late.ready", req_ready, 4'b0010);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
